qpsk_tx_sched: RTL and testbench



---
 rtl/qpsk_tx_sched.sv | 219 +++++++++++++++++++++
 tb/tb_qpsk_tx_sched.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_tx_sched.sv
// qpsk_tx_sched -- transmit symbol scheduler in front of the QPSK modulator.
//
// Takes a byte stream and serializes each byte MSB-first into 2-bit {I,Q}
// symbols, one strobe every sps cycles, pausing while the modulator is not
// ready. Frames are sized by a byte count latched on start. o_done pulses at
// normal frame end; o_underrun is sticky when a payload byte arrives late.
//
// Build option: define QPSK_SCHED_PREAMBLE_EN to prefix every frame with
// PREAMBLE_LEN alternating 00/11 symbols. Without it no preamble logic is
// built and start goes straight to the payload phase.
module qpsk_tx_sched #(
  parameter int SPS_W        = 8,
  parameter int PREAMBLE_LEN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [7:0]       i_len,
  input  logic [SPS_W-1:0] i_sps,
  input  logic [7:0]       i_data,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  input  logic             i_mod_ready,
  output logic             o_I,
  output logic             o_Q,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_underrun
);

  // Frame states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

`ifdef QPSK_SCHED_PREAMBLE_EN
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  // Preamble symbol index counts 0 .. PREAMBLE_LEN-1
  localparam int               PRE_W    = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);

  logic [PRE_W-1:0] pre_cnt_r;
`else
  // Preamble length has no meaning when the preamble is not built
  localparam int unused_preamble_len = PREAMBLE_LEN;
`endif

  logic [1:0]       state_r;
  logic [SPS_W-1:0] sps_r;          // latched samples-per-symbol, never 0
  logic [SPS_W-1:0] cnt_r;          // cycles until the next strobe is allowed
  logic [7:0]       bytes_left_r;   // payload bytes still to be accepted
  logic [7:0]       shift_r;        // current payload byte, symbol in [7:6]
  logic [2:0]       sym_left_r;     // symbols of shift_r not yet sent

  logic             busy_s;
  logic             abort_s;
  logic             start_s;
  logic             in_payload_s;
  logic             sym_avail_s;
  logic [1:0]       sym_s;
  logic             tick_s;
  logic             fire_s;
  logic             ready_s;
  logic             accept_s;
  logic             frame_end_s;
  logic             underrun_hit_s;

  // Symbol on offer and whether one is available in the current state
  always_comb begin
    sym_avail_s = 1'b0;
    sym_s       = 2'b00;
    case (state_r)
`ifdef QPSK_SCHED_PREAMBLE_EN
      ST_PREAMBLE: begin
        // even index -> 00, odd index -> 11
        sym_avail_s = 1'b1;
        sym_s       = {pre_cnt_r[0], pre_cnt_r[0]};
      end
`endif
      ST_PAYLOAD: begin
        sym_avail_s = (sym_left_r != 3'd0);
        sym_s       = shift_r[7:6];
      end
      default: begin
        sym_avail_s = 1'b0;
        sym_s       = 2'b00;
      end
    endcase
  end

  assign busy_s       = (state_r != ST_IDLE);
  assign abort_s      = i_abort & busy_s;
  // Abort outranks start, and start is only honoured when idle
  assign start_s      = i_start & ~i_abort & ~busy_s;
  assign in_payload_s = (state_r == ST_PAYLOAD);

  // A tick needs the spacing counter expired, the modulator ready and a symbol
  assign tick_s = (cnt_r == {SPS_W{1'b0}}) & i_mod_ready & sym_avail_s;
  assign fire_s = tick_s & ~abort_s;

  // Take the next byte when the shifter is empty, or when its last symbol
  // leaves this cycle so the following byte lines up without a slip
  assign ready_s = in_payload_s & (bytes_left_r != 8'd0) &
                   ((sym_left_r == 3'd0) | ((sym_left_r == 3'd1) & tick_s));
  // A byte handed over in the abort cycle is dropped with the frame
  assign accept_s = ready_s & i_data_valid & ~abort_s;

  assign frame_end_s = in_payload_s & (sym_left_r == 3'd0) & (bytes_left_r == 8'd0);

  // Last symbol of a byte goes out while the next byte is still owed
  assign underrun_hit_s = fire_s & in_payload_s & (sym_left_r == 3'd1) &
                          (bytes_left_r != 8'd0) & ~i_data_valid;

  assign o_data_ready = ready_s;
  assign o_busy       = busy_s;

  // Frame sequencing: state, latched frame parameters, preamble index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      sps_r        <= SPS_W'(1);
      bytes_left_r <= 8'd0;
`ifdef QPSK_SCHED_PREAMBLE_EN
      pre_cnt_r    <= {PRE_W{1'b0}};
`endif
    end else if (abort_s) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            // sps of 0 behaves as 1
            sps_r        <= (i_sps == {SPS_W{1'b0}}) ? SPS_W'(1) : i_sps;
            bytes_left_r <= i_len;
`ifdef QPSK_SCHED_PREAMBLE_EN
            pre_cnt_r    <= {PRE_W{1'b0}};
            state_r      <= ST_PREAMBLE;
`else
            state_r      <= ST_PAYLOAD;
`endif
          end
        end
`ifdef QPSK_SCHED_PREAMBLE_EN
        ST_PREAMBLE: begin
          if (fire_s) begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
            if (pre_cnt_r == PRE_LAST) begin
              state_r <= ST_PAYLOAD;
            end
          end
        end
`endif
        ST_PAYLOAD: begin
          if (frame_end_s) begin
            state_r <= ST_IDLE;
          end else if (accept_s) begin
            bytes_left_r <= bytes_left_r - 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobe spacing counter and the payload shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {SPS_W{1'b0}};
      sym_left_r <= 3'd0;
      shift_r    <= 8'd0;
    end else if (start_s) begin
      // first strobe may go out on the very next edge
      cnt_r      <= {SPS_W{1'b0}};
      sym_left_r <= 3'd0;
    end else begin
      if (fire_s) begin
        cnt_r <= sps_r - SPS_W'(1);
      end else if (cnt_r != {SPS_W{1'b0}}) begin
        cnt_r <= cnt_r - SPS_W'(1);
      end

      // a load in the same cycle as the last symbol's tick wins over the shift
      if (accept_s) begin
        shift_r    <= i_data;
        sym_left_r <= 3'd4;
      end else if (fire_s && in_payload_s) begin
        shift_r    <= {shift_r[5:0], 2'b00};
        sym_left_r <= sym_left_r - 3'd1;
      end
    end
  end

  // Registered modulator-facing strobe, symbol bits and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid    <= 1'b0;
      o_I        <= 1'b0;
      o_Q        <= 1'b0;
      o_done     <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_valid <= fire_s;
      // symbol bits hold their last value between strobes
      if (fire_s) begin
        {o_I, o_Q} <= sym_s;
      end
      o_done <= frame_end_s & ~abort_s;
      if (start_s) begin
        o_underrun <= 1'b0;
      end else if (underrun_hit_s) begin
        o_underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_tx_sched.sv
// tb_qpsk_tx_sched -- randomized self-checking bench for qpsk_tx_sched.
// The reference model keeps a queue of pending symbols and an earliest-strobe
// cycle number; strobes, loads, done and underrun are predicted from those.
// Honours QPSK_SCHED_PREAMBLE_EN the same way the design does.
module tb_qpsk_tx_sched;

  localparam int SPS_W   = 8;
  localparam int PRE_LEN = 16;
`ifdef QPSK_SCHED_PREAMBLE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_start, i_abort, i_data_valid, i_mod_ready;
  logic [7:0]       i_len, i_data;
  logic [SPS_W-1:0] i_sps;
  logic             o_data_ready, o_I, o_Q, o_valid, o_busy, o_done, o_underrun;

  always #5 clk = ~clk;

  qpsk_tx_sched #(.SPS_W(SPS_W), .PREAMBLE_LEN(PRE_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_len(i_len), .i_sps(i_sps), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .i_mod_ready(i_mod_ready),
    .o_I(o_I), .o_Q(o_Q), .o_valid(o_valid), .o_busy(o_busy),
    .o_done(o_done), .o_underrun(o_underrun)
  );

  int n_vec = 0;
  int n_err = 0;

  // Count one comparison and report it if it does not match
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit         m_busy, m_pay;
  int         m_len, m_sps, m_loaded, m_earliest, m_cyc, m_strobes, m_pstrobes;
  logic [1:0] m_q[$];
  logic [7:0] m_bytes[$];
  logic [7:0] fix_q[$];
  logic       e_valid, e_done, e_unr;
  logic [1:0] e_sym;

  function automatic bit m_tick();
    return m_busy && (m_q.size() > 0) && (m_cyc >= m_earliest) && (i_mod_ready === 1'b1);
  endfunction

  function automatic bit m_rdy();
    return m_busy && m_pay && (m_loaded < m_len) &&
           ((m_q.size() == 0) || ((m_q.size() == 1) && m_tick()));
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_pay = 1'b0; m_q.delete();
    e_valid = 1'b0; e_done = 1'b0; e_unr = 1'b0; e_sym = 2'b00;
  endtask

  task automatic model_edge();
    bit rdy, tk;
    logic [7:0] b;
    rdy = m_rdy();
    tk  = m_tick();
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (!m_busy) begin
      if (i_start && !i_abort) begin
        m_busy = 1'b1; m_len = int'(i_len);
        m_sps = (i_sps == '0) ? 1 : int'(i_sps);
        m_loaded = 0; m_earliest = m_cyc + 1; e_unr = 1'b0;
        m_strobes = 0; m_pstrobes = 0; m_q.delete();
        m_pay = !PRE_EN;
        if (PRE_EN) for (int k = 0; k < PRE_LEN; k++) m_q.push_back((k % 2) ? 2'b11 : 2'b00);
      end
    end else if (i_abort) begin
      m_busy = 1'b0;
    end else if (m_pay && m_q.size() == 0 && m_loaded == m_len) begin
      m_busy = 1'b0;
      e_done = 1'b1;
    end else begin
      if (tk) begin
        e_valid = 1'b1;
        e_sym = m_q.pop_front();
        m_earliest = m_cyc + m_sps;
        m_strobes++;
        if (m_pay) m_pstrobes++;
        if (m_pay && m_q.size() == 0 && m_loaded < m_len && !i_data_valid) e_unr = 1'b1;
      end
      if (rdy && i_data_valid) begin
        b = m_bytes[m_loaded];
        m_q.push_back(b[7:6]); m_q.push_back(b[5:4]);
        m_q.push_back(b[3:2]); m_q.push_back(b[1:0]);
        m_loaded++;
      end
      if (!m_pay && m_q.size() == 0) m_pay = 1'b1;
    end
    m_cyc++;
  endtask

  // ---------------- stimulus ----------------
  // One clock: check registered outputs, drive inputs, check ready, advance model
  task automatic run_cycle(input bit st, input bit ab, input bit rdy, input bit vld,
                           input logic [7:0] len, input logic [SPS_W-1:0] sps);
    @(negedge clk);
    chk("o_valid", o_valid, e_valid);
    chk("o_sym", {o_I, o_Q}, e_sym);
    chk("o_done", o_done, e_done);
    chk("o_underrun", o_underrun, e_unr);
    chk("o_busy", o_busy, m_busy);
    i_start = st; i_abort = ab; i_mod_ready = rdy; i_data_valid = vld;
    i_len = len; i_sps = sps;
    i_data = (m_loaded < m_bytes.size()) ? m_bytes[m_loaded] : 8'($urandom);
    #1;
    chk("o_data_ready", o_data_ready, m_rdy());
    @(posedge clk);
    model_edge();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_sym"}, {o_I, o_Q}, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_underrun"}, o_underrun, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_data_ready"}, o_data_ready, 0);
  endtask

  // Pull rst_n low between edges and expect every output to clear at once
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    i_start = 1'b0; i_abort = 1'b0; i_data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input int len, input int sps, input int rdy_pct, input int vld_pct,
                           input int abort_at, input int rst_at,
                           input int wh_at, input int wh_len,
                           input int bp_at, input int bp_len, input bit noise);
    int wh_left = 0;
    int bp_left = 0;
    bit wh_done = 1'b0, bp_done = 1'b0, ab_done = 1'b0, was_rst = 1'b0;
    bit ab, st, rdy, vld;
    int n = 0;
    m_bytes.delete();
    for (int i = 0; i < len; i++) begin
      if (fix_q.size() > 0) m_bytes.push_back(fix_q.pop_front());
      else m_bytes.push_back(8'($urandom));
    end
    run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'(len), SPS_W'(sps));
    while (m_busy && n < 4000) begin
      if (rst_at > 0 && m_strobes >= rst_at) begin
        do_reset();
        was_rst = 1'b1;
        break;
      end
      if (!wh_done && wh_at > 0 && m_pstrobes >= wh_at) begin wh_left = wh_len; wh_done = 1'b1; end
      if (!bp_done && bp_at > 0 && m_pstrobes >= bp_at) begin bp_left = bp_len; bp_done = 1'b1; end
      ab = !ab_done && abort_at > 0 && m_strobes >= abort_at;
      if (ab) ab_done = 1'b1;
      rdy = (bp_left > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      if (bp_left > 0) bp_left--;
      vld = (wh_left > 0) ? 1'b0 : ($urandom_range(99) < vld_pct);
      if (wh_left > 0) wh_left--;
      st = noise && ($urandom_range(7) == 0);
      run_cycle(st, ab, rdy, vld, noise ? 8'($urandom) : 8'(len),
                noise ? SPS_W'($urandom) : SPS_W'(sps));
      n++;
    end
    chk("frame_in_budget", (n < 4000), 1);
    if (!was_rst) begin
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'(len), SPS_W'(sps));
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'(len), SPS_W'(sps));
    end
  endtask

  // Hard stop in case something never returns to idle
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_start = 1'b0; i_abort = 1'b0; i_data_valid = 1'b0; i_mod_ready = 1'b1;
    i_len = 8'd0; i_sps = SPS_W'(1); i_data = 8'd0;
    m_cyc = 0;
    model_reset();
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // preamble + single byte, sps 4
    fix_q.push_back(8'h1B);
    run_frame(1, 4, 100, 100, 0, 0, 0, 0, 0, 0, 1'b0);
    // back-to-back payload, sps 1
    fix_q.push_back(8'hE4); fix_q.push_back(8'h39);
    run_frame(2, 1, 100, 100, 0, 0, 0, 0, 0, 0, 1'b0);
    // second byte late
    run_frame(2, 2, 100, 100, 0, 0, 3, 12, 0, 0, 1'b0);
    // modulator backpressure for 7 cycles
    run_frame(3, 3, 100, 100, 0, 0, 0, 0, 2, 7, 1'b0);
    // abort at the 5th symbol, then a full frame
    run_frame(2, 2, 100, 100, 5, 0, 0, 0, 0, 0, 1'b0);
    run_frame(2, 2, 100, 100, 0, 0, 0, 0, 0, 0, 1'b0);
    // reset mid-frame, then sps 0 / len 0
    run_frame(3, 2, 100, 100, 0, 7, 0, 0, 0, 0, 1'b0);
    run_frame(0, 0, 100, 100, 0, 0, 0, 0, 0, 0, 1'b0);

    // randomized frames with noise on start/len/sps while busy
    for (int f = 0; f < 25; f++) begin
      run_frame(int'($urandom_range(5)), int'($urandom_range(4)),
                int'($urandom_range(100, 50)), int'($urandom_range(100, 40)),
                ($urandom_range(5) == 0) ? int'($urandom_range(20, 1)) : 0, 0,
                0, 0, 0, 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
